// File: rtl/pipeline_ctrl_pkg.sv
// Shared definitions for the pipeline sequencer: FSM state encodings and
// ID/EX mem-field layout.
package pipeline_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_RUN  = 2'd0,
    ST_HALT = 2'd1,
    ST_STEP = 2'd2
  } ctrl_state_e;

  // Bit position of MemRead inside the ID/EX mem control field
  localparam int unsigned IDEX_MEM_MEMREAD_BIT = 1;

endpackage

// File: rtl/pipeline_ctrl_hazard_detect.sv
// Load-use hazard compare: the load in ID/EX writes a register that the
// instruction in ID reads.
module hazard_detect
  import pipeline_ctrl_pkg::*;
(
  input  logic [4:0] ifid_rs,
  input  logic [4:0] ifid_rt,
  input  logic       ifid_uses_rt,
  input  logic [4:0] idex_rt,
  input  logic       idex_memread,
  output logic       load_use
);

  logic rs_match;
  logic rt_match;

  always_comb begin
    rs_match = (idex_rt == ifid_rs);
    rt_match = ifid_uses_rt & (idex_rt == ifid_rt);
    // $0 is never a real destination, so a load into it cannot hazard
    load_use = idex_memread & (idex_rt != 5'd0) & (rs_match | rt_match);
  end

endmodule

// File: rtl/pipeline_ctrl.sv
// Pipeline register / PC sequencer with load-use stall, branch flush and
// debug HALT/STEP/RUN. Optional perf counters under PIPE_CTRL_PERF_EN.
module pipeline_ctrl
  import pipeline_ctrl_pkg::*;
#(
  parameter int unsigned LOAD_STALL_CYCLES = 1,
  parameter bit          START_HALTED      = 1'b0
) (
  input  logic        i_clock,
  input  logic        i_reset,
  input  logic [4:0]  i_ifid_rs,
  input  logic [4:0]  i_ifid_rt,
  input  logic        i_ifid_uses_rt,
  input  logic [4:0]  i_idex_rt,
  input  logic        i_idex_memread,
  input  logic        i_branch_taken,
  input  logic        i_halt_instr,
  input  logic        i_dbg_halt,
  input  logic        i_dbg_step,
  input  logic        i_dbg_run,
  output logic        o_pc_write,
  output logic        o_ifid_write,
  output logic        o_ifid_flush,
  output logic        o_idex_write,
  output logic        o_idex_bubble,
  output logic        o_exmem_write,
  output logic        o_memwb_write,
  output logic        o_halted,
  output logic [31:0] o_stall_count,
  output logic [31:0] o_flush_count,
  output logic [31:0] o_cycle_count
);

  localparam int unsigned     STALL_W      = $clog2(LOAD_STALL_CYCLES + 1);
  localparam logic [STALL_W-1:0] STALL_RELOAD = STALL_W'(LOAD_STALL_CYCLES - 1);
  localparam ctrl_state_e     RESET_STATE  = START_HALTED ? ST_HALT : ST_RUN;

  ctrl_state_e        state, state_nxt;
  logic [STALL_W-1:0] stall_cnt, stall_cnt_nxt;
  logic               load_use;
  logic               tick;
  logic               flush;
  logic               stall;

  hazard_detect u_hazard (
    .ifid_rs      (i_ifid_rs),
    .ifid_rt      (i_ifid_rt),
    .ifid_uses_rt (i_ifid_uses_rt),
    .idex_rt      (i_idex_rt),
    .idex_memread (i_idex_memread),
    .load_use     (load_use)
  );

  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset) begin
      state     <= RESET_STATE;
      stall_cnt <= '0;
    end else begin
      state     <= state_nxt;
      stall_cnt <= stall_cnt_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      ST_RUN:  if (i_dbg_halt || i_halt_instr) state_nxt = ST_HALT;
      ST_HALT: begin
        if (i_dbg_halt)      state_nxt = ST_HALT;
        else if (i_dbg_step) state_nxt = ST_STEP;
        else if (i_dbg_run)  state_nxt = ST_RUN;
      end
      ST_STEP: state_nxt = ST_HALT;
      default: state_nxt = RESET_STATE;
    endcase
  end

  // Stall counter holds the remaining extra stall cycles and is frozen in
  // HALT, so a stall interrupted by a debug halt resumes on STEP/RUN.
  always_comb begin
    tick          = (state != ST_HALT);
    flush         = tick & i_branch_taken;
    stall         = tick & ~flush & ((stall_cnt != '0) | load_use);
    stall_cnt_nxt = stall_cnt;
    if (tick) begin
      if (flush)                  stall_cnt_nxt = '0;
      else if (stall_cnt != '0)   stall_cnt_nxt = stall_cnt - 1'b1;
      else if (load_use)          stall_cnt_nxt = STALL_RELOAD;
    end
  end

  assign o_pc_write    = tick & ~stall;
  assign o_ifid_write  = tick & ~stall;
  assign o_ifid_flush  = flush;
  assign o_idex_bubble = tick & (stall | flush);
  assign o_idex_write  = tick;
  assign o_exmem_write = tick;
  assign o_memwb_write = tick;
  assign o_halted      = ~tick;

`ifdef PIPE_CTRL_PERF_EN
  logic [31:0] stall_q, flush_q, cycle_q;

  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset) begin
      stall_q <= '0;
      flush_q <= '0;
      cycle_q <= '0;
    end else begin
      if (tick)  cycle_q <= cycle_q + 32'd1;
      if (stall) stall_q <= stall_q + 32'd1;
      if (flush) flush_q <= flush_q + 32'd1;
    end
  end

  assign o_stall_count = stall_q;
  assign o_flush_count = flush_q;
  assign o_cycle_count = cycle_q;
`else
  assign o_stall_count = '0;
  assign o_flush_count = '0;
  assign o_cycle_count = '0;
`endif

endmodule

// File: tb/tb_pipeline_ctrl.sv
// Directed bench for pipeline_ctrl: three instances (1-cycle stall, 3-cycle
// stall, start-halted) share one stimulus bus.
module tb_pipeline_ctrl;

  logic       i_clock = 1'b0;
  logic       i_reset;
  logic [4:0] i_ifid_rs, i_ifid_rt, i_idex_rt;
  logic       i_ifid_uses_rt, i_idex_memread, i_branch_taken;
  logic       i_halt_instr, i_dbg_halt, i_dbg_step, i_dbg_run;

  logic        pc_w[3], ifid_w[3], ifid_f[3], idex_w[3], idex_b[3];
  logic        exmem_w[3], memwb_w[3], halted[3];
  logic [31:0] stall_c[3], flush_c[3], cycle_c[3];

  int checks = 0;
  int errors = 0;

  always #5 i_clock = ~i_clock;

  pipeline_ctrl #(.LOAD_STALL_CYCLES(1), .START_HALTED(1'b0)) u_dut1 (
    .i_clock(i_clock), .i_reset(i_reset), .i_ifid_rs(i_ifid_rs), .i_ifid_rt(i_ifid_rt),
    .i_ifid_uses_rt(i_ifid_uses_rt), .i_idex_rt(i_idex_rt), .i_idex_memread(i_idex_memread),
    .i_branch_taken(i_branch_taken), .i_halt_instr(i_halt_instr), .i_dbg_halt(i_dbg_halt),
    .i_dbg_step(i_dbg_step), .i_dbg_run(i_dbg_run), .o_pc_write(pc_w[0]),
    .o_ifid_write(ifid_w[0]), .o_ifid_flush(ifid_f[0]), .o_idex_write(idex_w[0]),
    .o_idex_bubble(idex_b[0]), .o_exmem_write(exmem_w[0]), .o_memwb_write(memwb_w[0]),
    .o_halted(halted[0]), .o_stall_count(stall_c[0]), .o_flush_count(flush_c[0]),
    .o_cycle_count(cycle_c[0]));

  pipeline_ctrl #(.LOAD_STALL_CYCLES(3), .START_HALTED(1'b0)) u_dut3 (
    .i_clock(i_clock), .i_reset(i_reset), .i_ifid_rs(i_ifid_rs), .i_ifid_rt(i_ifid_rt),
    .i_ifid_uses_rt(i_ifid_uses_rt), .i_idex_rt(i_idex_rt), .i_idex_memread(i_idex_memread),
    .i_branch_taken(i_branch_taken), .i_halt_instr(i_halt_instr), .i_dbg_halt(i_dbg_halt),
    .i_dbg_step(i_dbg_step), .i_dbg_run(i_dbg_run), .o_pc_write(pc_w[1]),
    .o_ifid_write(ifid_w[1]), .o_ifid_flush(ifid_f[1]), .o_idex_write(idex_w[1]),
    .o_idex_bubble(idex_b[1]), .o_exmem_write(exmem_w[1]), .o_memwb_write(memwb_w[1]),
    .o_halted(halted[1]), .o_stall_count(stall_c[1]), .o_flush_count(flush_c[1]),
    .o_cycle_count(cycle_c[1]));

  pipeline_ctrl #(.LOAD_STALL_CYCLES(1), .START_HALTED(1'b1)) u_duth (
    .i_clock(i_clock), .i_reset(i_reset), .i_ifid_rs(i_ifid_rs), .i_ifid_rt(i_ifid_rt),
    .i_ifid_uses_rt(i_ifid_uses_rt), .i_idex_rt(i_idex_rt), .i_idex_memread(i_idex_memread),
    .i_branch_taken(i_branch_taken), .i_halt_instr(i_halt_instr), .i_dbg_halt(i_dbg_halt),
    .i_dbg_step(i_dbg_step), .i_dbg_run(i_dbg_run), .o_pc_write(pc_w[2]),
    .o_ifid_write(ifid_w[2]), .o_ifid_flush(ifid_f[2]), .o_idex_write(idex_w[2]),
    .o_idex_bubble(idex_b[2]), .o_exmem_write(exmem_w[2]), .o_memwb_write(memwb_w[2]),
    .o_halted(halted[2]), .o_stall_count(stall_c[2]), .o_flush_count(flush_c[2]),
    .o_cycle_count(cycle_c[2]));

  typedef struct {
    logic [4:0] rs, rt, idex_rt;
    logic       uses_rt, memread, branch;
    logic       exp_pc, exp_flush, exp_bubble;
  } vec_t;

  // Counter outputs read as zero unless the perf feature is built in
  function automatic logic [31:0] perf(input logic [31:0] v);
`ifdef PIPE_CTRL_PERF_EN
    return v;
`else
    return 32'd0;
`endif
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic cyc();
    @(posedge i_clock);
    #1;
  endtask

  task automatic clear_inputs();
    i_ifid_rs = '0; i_ifid_rt = '0; i_ifid_uses_rt = 1'b0; i_idex_rt = '0;
    i_idex_memread = 1'b0; i_branch_taken = 1'b0; i_halt_instr = 1'b0;
    i_dbg_halt = 1'b0; i_dbg_step = 1'b0; i_dbg_run = 1'b0;
  endtask

  task automatic pulse_reset();
    i_reset = 1'b1;
    #1;
    i_reset = 1'b0;
    #1;
  endtask

  task automatic set_lw5(input logic on);
    i_idex_memread = on; i_idex_rt = 5'd5; i_ifid_rs = 5'd5;
  endtask

  // Enables of one instance in a ticking cycle: {pc, ifid_w, flush, bubble, idex_w, exmem_w, memwb_w}
  task automatic chk_en(input string name, input int k, input logic [6:0] exp);
    chk(name, {pc_w[k], ifid_w[k], ifid_f[k], idex_b[k], idex_w[k], exmem_w[k], memwb_w[k]}, {25'd0, exp});
  endtask

  vec_t vecs[8];

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    clear_inputs();
    i_reset = 1'b1;
    #12;
    chk("rst_halted_run", halted[0], 1'b0);
    chk_en("rst_en_run", 0, 7'b1100111);
    chk("rst_halted_starthalted", halted[2], 1'b1);
    chk_en("rst_en_starthalted", 2, 7'b0000000);
    chk("rst_cycles", cycle_c[0], 32'd0);
    i_reset = 1'b0;

    vecs[0] = '{rs:0, rt:0, idex_rt:0, uses_rt:0, memread:0, branch:0, exp_pc:1, exp_flush:0, exp_bubble:0};
    vecs[1] = '{rs:5, rt:0, idex_rt:5, uses_rt:0, memread:1, branch:0, exp_pc:0, exp_flush:0, exp_bubble:1};
    vecs[2] = '{rs:3, rt:5, idex_rt:5, uses_rt:1, memread:1, branch:0, exp_pc:0, exp_flush:0, exp_bubble:1};
    vecs[3] = '{rs:3, rt:5, idex_rt:5, uses_rt:0, memread:1, branch:0, exp_pc:1, exp_flush:0, exp_bubble:0};
    vecs[4] = '{rs:0, rt:0, idex_rt:0, uses_rt:1, memread:1, branch:0, exp_pc:1, exp_flush:0, exp_bubble:0};
    vecs[5] = '{rs:5, rt:5, idex_rt:5, uses_rt:1, memread:0, branch:0, exp_pc:1, exp_flush:0, exp_bubble:0};
    vecs[6] = '{rs:1, rt:2, idex_rt:7, uses_rt:1, memread:0, branch:1, exp_pc:1, exp_flush:1, exp_bubble:1};
    vecs[7] = '{rs:5, rt:0, idex_rt:5, uses_rt:0, memread:1, branch:1, exp_pc:1, exp_flush:1, exp_bubble:1};

    for (int i = 0; i < 8; i++) begin
      i_ifid_rs = vecs[i].rs; i_ifid_rt = vecs[i].rt; i_idex_rt = vecs[i].idex_rt;
      i_ifid_uses_rt = vecs[i].uses_rt; i_idex_memread = vecs[i].memread;
      i_branch_taken = vecs[i].branch;
      #1;
      chk_en($sformatf("vec%0d_en", i), 0,
             {vecs[i].exp_pc, vecs[i].exp_pc, vecs[i].exp_flush, vecs[i].exp_bubble, 3'b111});
      cyc();
    end
    clear_inputs();
    chk("vec_cycle_count", cycle_c[0], perf(32'd8));
    chk("vec_stall_count", stall_c[0], perf(32'd2));
    chk("vec_flush_count", flush_c[0], perf(32'd2));

    // Single-cycle load-use stall
    pulse_reset();
    set_lw5(1'b1);
    #1;
    chk_en("lw1_c1", 0, 7'b0001111);
    cyc();
    set_lw5(1'b0);
    #1;
    chk_en("lw1_c2", 0, 7'b1100111);
    chk("lw1_stall_count", stall_c[0], perf(32'd1));

    // Three-cycle stall persists after load_use drops
    pulse_reset();
    set_lw5(1'b1);
    #1;
    chk_en("lw3_c1", 1, 7'b0001111);
    cyc();
    set_lw5(1'b0);
    #1;
    chk_en("lw3_c2", 1, 7'b0001111);
    cyc();
    chk_en("lw3_c3", 1, 7'b0001111);
    cyc();
    chk_en("lw3_c4", 1, 7'b1100111);
    chk("lw3_stall_count", stall_c[1], perf(32'd3));

    // Branch beats load-use and leaves no residual stall
    pulse_reset();
    set_lw5(1'b1);
    i_branch_taken = 1'b1;
    #1;
    chk_en("br_lu_c1", 1, 7'b1111111);
    cyc();
    clear_inputs();
    #1;
    chk_en("br_lu_c2", 1, 7'b1100111);
    chk("br_lu_flush_count", flush_c[1], perf(32'd1));

    // Debug halt taking effect after the first of three stall cycles
    pulse_reset();
    set_lw5(1'b1);
    i_dbg_halt = 1'b1;
    #1;
    chk_en("dh_c1", 1, 7'b0001111);
    cyc();
    clear_inputs();
    #1;
    chk("dh_halted", halted[1], 1'b1);
    chk_en("dh_en", 1, 7'b0000000);
    cyc();
    chk("dh_hold", halted[1], 1'b1);
    for (int s = 0; s < 3; s++) begin
      i_dbg_step = 1'b1;
      cyc();
      i_dbg_step = 1'b0;
      #1;
      chk($sformatf("step%0d_halted", s), halted[1], 1'b0);
      chk_en($sformatf("step%0d_en", s), 1, (s < 2) ? 7'b0001111 : 7'b1100111);
      cyc();
      chk($sformatf("step%0d_rehalt", s), halted[1], 1'b1);
    end

    // HALT opcode, resume, debug-halt priority over run, reset mid-HALT
    pulse_reset();
    i_halt_instr = 1'b1;
    #1;
    chk("hi_same_cycle", halted[0], 1'b0);
    cyc();
    i_halt_instr = 1'b0;
    #1;
    chk("hi_next_cycle", halted[0], 1'b1);
    i_dbg_run = 1'b1;
    cyc();
    i_dbg_run = 1'b0;
    #1;
    chk("run_resumed", halted[0], 1'b0);
    chk_en("run_en", 0, 7'b1100111);
    chk("starthalted_run", halted[2], 1'b0);
    i_dbg_halt = 1'b1;
    cyc();
    i_dbg_run = 1'b1;
    cyc();
    #1;
    chk("halt_beats_run", halted[0], 1'b1);
    clear_inputs();
    chk("pre_reset_cycles", cycle_c[0], perf(32'd2));
    i_reset = 1'b1;
    #1;
    chk("rst_mid_halt", halted[0], 1'b0);
    chk("rst_mid_halt_cycles", cycle_c[0], 32'd0);
    chk("rst_mid_halt_starthalted", halted[2], 1'b1);
    i_reset = 1'b0;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
